// File: rtl/captura_contador_pkg.sv
// Shared definitions for the counter-capture stage: capture FSM encoding and default widths.
package captura_contador_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cap_state_t;

    localparam int CNT_W_DEF = 4;
    localparam int EXT_W_DEF = 8;

endpackage

// File: rtl/captura_contador_detector_vuelta.sv
// Remembers the previously sampled count and flags wraps (max -> 0) and illegal jumps.
module detector_vuelta #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_wrap,
    output logic             o_err
);

    logic [CNT_W-1:0] r_prev;
    logic [CNT_W-1:0] w_prev_inc;

    assign w_prev_inc = r_prev + CNT_W'(1);

    // Both flags are pulses, only meaningful while tracking is enabled
    assign o_wrap = i_en && (r_prev == {CNT_W{1'b1}}) && (i_cnt == '0);
    assign o_err  = i_en && (i_cnt != r_prev) && (i_cnt != w_prev_inc);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_prev <= '0;
        else if (i_en)
            r_prev <= i_cnt;
    end

endmodule

// File: rtl/captura_contador.sv
// Samples the upstream JK count, extends it with a wrap counter, flags compare matches
// and sequence errors, and freezes snapshots through a request/valid/ack handshake.
module captura_contador
    import captura_contador_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int EXT_W = EXT_W_DEF
) (
    input  logic                   C,
    input  logic                   R,
    input  logic [CNT_W-1:0]       CNT,
    input  logic                   EN,
    input  logic [CNT_W+EXT_W-1:0] CMP,
    input  logic                   CAP_REQ,
    input  logic                   CAP_ACK,
    output logic [CNT_W+EXT_W-1:0] FULL,
    output logic                   MATCH,
    output logic [CNT_W+EXT_W-1:0] SNAP,
    output logic                   VALID,
    output logic                   OVR,
    output logic                   ERR
);

    localparam int W = CNT_W + EXT_W;

    logic             w_wrap;
    logic             w_err;
    logic [EXT_W-1:0] w_ext_next;
    logic [W-1:0]     w_full_next;
    logic             w_eq_next;

    logic [EXT_W-1:0] r_ext;
    logic [W-1:0]     r_full;
    logic             r_eq;
    logic             r_match;
    logic             r_err;
    logic [W-1:0]     r_snap;
    logic             r_valid;
    logic             r_ovr;
    cap_state_t       r_state;

    detector_vuelta #(
        .CNT_W (CNT_W)
    ) u_det (
        .i_clk  (C),
        .i_rst  (R),
        .i_en   (EN),
        .i_cnt  (CNT),
        .o_wrap (w_wrap),
        .o_err  (w_err)
    );

    assign w_ext_next  = w_wrap ? r_ext + EXT_W'(1) : r_ext;
    assign w_full_next = EN ? {w_ext_next, CNT} : r_full;
    // Equality as it will be seen after this edge; r_eq holds the previous edge's view,
    // so either a count change or a CMP change can produce the rising edge of equality
    assign w_eq_next   = (w_full_next == CMP);

    always_ff @(posedge C) begin
        if (R) begin
            r_ext  <= '0;
            r_full <= '0;
        end else if (EN) begin
            r_ext  <= w_ext_next;
            r_full <= w_full_next;
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_eq    <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_eq    <= w_eq_next;
            r_match <= w_eq_next && !r_eq;
        end
    end

    always_ff @(posedge C) begin
        if (R)
            r_err <= 1'b0;
        else if (w_err)
            r_err <= 1'b1;
    end

    // In HOLD an ack with a simultaneous request retires the old snapshot and takes a new one
    always_ff @(posedge C) begin
        if (R) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (CAP_REQ) begin
                        r_snap  <= w_full_next;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (CAP_ACK && CAP_REQ) begin
                        r_snap <= w_full_next;
                    end else if (CAP_ACK) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end else if (CAP_REQ) begin
                        r_ovr <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign FULL  = r_full;
    assign MATCH = r_match;
    assign SNAP  = r_snap;
    assign VALID = r_valid;
    assign OVR   = r_ovr;
    assign ERR   = r_err;

endmodule

// File: tb/tb_captura_contador.sv
// Bench for captura_contador: JK counter source, behavioural reference, directed scenarios.
module tb_captura_contador;

    logic        C;
    logic        R;
    logic [3:0]  CNT;
    logic        EN;
    logic [11:0] CMP;
    logic        CAP_REQ;
    logic        CAP_ACK;
    logic [11:0] FULL;
    logic        MATCH;
    logic [11:0] SNAP;
    logic        VALID;
    logic        OVR;
    logic        ERR;

    int n_tests = 0;
    int n_fail  = 0;
    int match_cnt = 0;
    bit chk_en = 0;

    // Upstream 4-bit JK counter (J=K=T), updating on the falling edge
    logic [3:0] jk_q = 4'd0;
    logic [3:0] jk_t;
    logic [3:0] jk_n;
    logic       jk_clr = 1'b1;
    logic       jk_run = 1'b0;
    logic       use_jk = 1'b0;
    logic [3:0] cnt_drv = 4'd0;

    assign jk_t = {&jk_q[2:0], &jk_q[1:0], jk_q[0], 1'b1};
    assign jk_n = (jk_t & ~jk_q) | (~jk_t & jk_q);

    always @(negedge C) begin
        if (jk_clr)
            jk_q <= 4'd0;
        else if (jk_run)
            jk_q <= jk_n;
    end

    assign CNT = use_jk ? jk_q : cnt_drv;

    captura_contador dut (
        .C       (C),
        .R       (R),
        .CNT     (CNT),
        .EN      (EN),
        .CMP     (CMP),
        .CAP_REQ (CAP_REQ),
        .CAP_ACK (CAP_ACK),
        .FULL    (FULL),
        .MATCH   (MATCH),
        .SNAP    (SNAP),
        .VALID   (VALID),
        .OVR     (OVR),
        .ERR     (ERR)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count kept as plain integers, extension = number of observed wraps
    int m_prev, m_ext, m_full, m_snap;
    bit m_match, m_eq_seen, m_valid, m_ovr, m_err;

    initial begin
        int nf;
        int step_sz;
        bit eq_now;
        m_prev = 0; m_ext = 0; m_full = 0; m_snap = 0;
        m_match = 0; m_eq_seen = 0; m_valid = 0; m_ovr = 0; m_err = 0;
        forever begin
            @(posedge C);
            if (R) begin
                m_prev = 0; m_ext = 0; m_full = 0; m_snap = 0;
                m_match = 0; m_eq_seen = 0; m_valid = 0; m_ovr = 0; m_err = 0;
            end else begin
                nf = m_full;
                if (EN) begin
                    step_sz = (int'(CNT) - m_prev + 16) % 16;
                    if (step_sz > 1) m_err = 1;
                    if (m_prev == 15 && CNT == 0) m_ext = (m_ext + 1) % 256;
                    m_prev = int'(CNT);
                    nf = m_ext * 16 + int'(CNT);
                end
                eq_now    = (nf == int'(CMP));
                m_match   = eq_now && !m_eq_seen;
                m_eq_seen = eq_now;
                if (CAP_REQ && (!m_valid || CAP_ACK)) begin
                    m_snap  = nf;
                    m_valid = 1;
                end else if (m_valid && CAP_ACK) begin
                    m_valid = 0;
                end else if (m_valid && CAP_REQ) begin
                    m_ovr = 1;
                end
                m_full = nf;
            end
        end
    end

    initial begin
        forever begin
            @(negedge C);
            if (chk_en) begin
                chk("FULL",  int'(FULL),  m_full);
                chk("MATCH", int'(MATCH), int'(m_match));
                chk("SNAP",  int'(SNAP),  m_snap);
                chk("VALID", int'(VALID), int'(m_valid));
                chk("OVR",   int'(OVR),   int'(m_ovr));
                chk("ERR",   int'(ERR),   int'(m_err));
                if (MATCH === 1'b1) match_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge C);
            #1;
        end
    endtask

    task automatic do_reset(input bit run_jk);
        R = 1'b1;
        jk_clr = 1'b1;
        jk_run = 1'b0;
        step(2);
        R = 1'b0;
        jk_clr = 1'b0;
        jk_run = run_jk;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        R = 1'b1; EN = 1'b1; CMP = 12'h013; CAP_REQ = 1'b1; CAP_ACK = 1'b0;
        use_jk = 1'b0; cnt_drv = 4'd9;

        // Reset dominates a pending request and a nonzero count
        step(2);
        chk("rst_FULL",  int'(FULL),  0);
        chk("rst_MATCH", int'(MATCH), 0);
        chk("rst_SNAP",  int'(SNAP),  0);
        chk("rst_VALID", int'(VALID), 0);
        chk("rst_OVR",   int'(OVR),   0);
        chk("rst_ERR",   int'(ERR),   0);
        chk_en = 1'b1;

        // Free-running JK counter with a compare at 0x013
        CAP_REQ = 1'b0;
        use_jk = 1'b1;
        R = 1'b0; jk_clr = 1'b0; jk_run = 1'b1;
        match_cnt = 0;
        step(19);
        chk("run_FULL_13",  int'(FULL),  12'h013);
        chk("run_MATCH_13", int'(MATCH), 1);
        step(1);
        chk("run_MATCH_14", int'(MATCH), 0);
        step(12);
        chk("run_FULL_20",  int'(FULL),  12'h020);
        step(8);
        chk("run_FULL_28",  int'(FULL),  12'h028);
        chk("run_ERR",      int'(ERR),   0);
        chk("run_match_cnt", match_cnt,  1);

        // Stall at the compare value: no second pulse
        use_jk = 1'b0;
        do_reset(1'b0);
        for (int i = 1; i <= 19; i++) begin
            cnt_drv = 4'(i % 16);
            step(1);
        end
        chk("stall_FULL",  int'(FULL),  12'h013);
        chk("stall_MATCH", int'(MATCH), 1);
        EN = 1'b0;
        step(3);
        chk("stall_hold_MATCH", int'(MATCH), 0);
        chk("stall_hold_FULL",  int'(FULL),  12'h013);
        EN = 1'b1;
        step(2);
        chk("stall_resume_MATCH", int'(MATCH), 0);
        chk("stall_resume_ERR",   int'(ERR),   0);

        // Capture, overrun, acknowledge
        use_jk = 1'b1;
        do_reset(1'b1);
        step(5);
        chk("cap_FULL5", int'(FULL), 12'h005);
        CAP_REQ = 1'b1;
        step(1);
        CAP_REQ = 1'b0;
        chk("cap_SNAP",  int'(SNAP),  12'h006);
        chk("cap_VALID", int'(VALID), 1);
        CAP_REQ = 1'b1;
        step(1);
        CAP_REQ = 1'b0;
        chk("ovr_OVR",   int'(OVR),   1);
        chk("ovr_SNAP",  int'(SNAP),  12'h006);
        CAP_ACK = 1'b1;
        step(1);
        chk("ack_VALID", int'(VALID), 0);
        step(1);
        CAP_ACK = 1'b0;
        chk("idle_ack_VALID", int'(VALID), 0);
        chk("idle_ack_SNAP",  int'(SNAP),  12'h006);

        // Simultaneous request and ack while holding
        do_reset(1'b1);
        step(2);
        CAP_REQ = 1'b1;
        step(1);
        CAP_REQ = 1'b0;
        chk("both_first_SNAP", int'(SNAP), 12'h003);
        step(1);
        CAP_REQ = 1'b1; CAP_ACK = 1'b1;
        step(1);
        CAP_REQ = 1'b0; CAP_ACK = 1'b0;
        chk("both_SNAP",  int'(SNAP),  12'h005);
        chk("both_VALID", int'(VALID), 1);
        chk("both_OVR",   int'(OVR),   0);

        // Illegal jump 3 -> 7 is sticky and leaves the extension alone
        use_jk = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: cnt_drv = 4'd1;
                1: cnt_drv = 4'd2;
                2: cnt_drv = 4'd3;
                3: cnt_drv = 4'd7;
                default: cnt_drv = 4'd8;
            endcase
            step(1);
            if (i == 3) begin
                chk("err_ERR",  int'(ERR),  1);
                chk("err_FULL", int'(FULL), 12'h007);
            end
        end
        chk("err_sticky", int'(ERR), 1);

        // Extension counter wraps from 255 back to 0
        use_jk = 1'b1;
        do_reset(1'b1);
        step(4095);
        chk("wrap_FULL_fff", int'(FULL), 12'hFFF);
        step(1);
        chk("wrap_FULL_000", int'(FULL), 12'h000);
        chk("wrap_ERR",      int'(ERR),  0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
